// File: rtl/morph_program_sequencer.sv
// Sequencer feeding one packed program to MorphologicProcessor, one instruction per ce cycle.
// Optional MORPH_SEQ_EARLY_STOP_EN: an instruction with el==0 ends the program early.
module morph_program_sequencer #(
  parameter int ImageWidth     = 32,
  parameter int ImageHeight    = 32,
  parameter int ProgramLength  = 4,
  parameter int OpCounterWidth = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  // packed program; cannot be called "program" because that is an SV keyword
  input  logic [16*ProgramLength-1:0]         chromosome,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [8:0]                          el,
  output logic [2:0]                          morphOp,
  output logic                                morphInSelect,
  output logic [2:0]                          logicOp,
  output logic                                ce,
  output logic                                procRst,
  input  logic [OpCounterWidth-1:0]           opCounter,
  input  logic [ImageWidth*ImageHeight-1:0]   imageAcc,
  output logic [ImageWidth*ImageHeight-1:0]   result
);

  localparam int IdxW = $clog2(ProgramLength + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, CAPTURE} state_t;

  state_t                     state;
  logic [IdxW-1:0]            index;
  logic [16*ProgramLength-1:0] snap;
  logic [15:0]                instr;
  logic                       marker;
  logic                       issue;

  always_comb begin
    instr = '0;
    for (int unsigned i = 0; i < ProgramLength; i++) begin
      if (index == IdxW'(i)) instr = snap[16*i +: 16];
    end
  end

`ifdef MORPH_SEQ_EARLY_STOP_EN
  assign marker = (instr[8:0] == 9'h000);
`else
  assign marker = 1'b0;
`endif

  assign issue         = (state == RUN) && !marker;
  assign ce            = issue;
  assign el            = issue ? instr[8:0]   : '0;
  assign morphOp       = issue ? instr[11:9]  : '0;
  assign morphInSelect = issue ? instr[12]    : 1'b0;
  assign logicOp       = issue ? instr[15:13] : '0;

  // index leaves RUN holding the executed count, which CAPTURE checks against opCounter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      result  <= '0;
      index   <= '0;
      snap    <= '0;
      procRst <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          procRst <= 1'b0;
          if (start) begin
            snap    <= chromosome;
            error   <= 1'b0;
            busy    <= 1'b1;
            procRst <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          procRst <= 1'b0;
          index   <= '0;
          state   <= RUN;
        end
        RUN: begin
          if (marker) begin
            state <= CAPTURE;
          end else begin
            index <= index + 1'b1;
            if (index == IdxW'(ProgramLength - 1)) state <= CAPTURE;
          end
        end
        CAPTURE: begin
          result <= imageAcc;
          done   <= 1'b1;
          busy   <= 1'b0;
          error  <= (opCounter != OpCounterWidth'(index));
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morph_program_sequencer.sv
// Scoreboard bench: driver pushes expected issues/results from a program-level model; monitor pops on ce/done.
module tb_morph_program_sequencer;
  localparam int PL = 4;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int NB = IW * IH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [16*PL-1:0] prog = '0;
  logic busy, done, error, morphInSelect, ce, procRst;
  logic [8:0] el;
  logic [2:0] morphOp, logicOp;
  logic [1:0] opCounter;
  logic [NB-1:0] imageAcc = '0;
  logic [NB-1:0] result;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct { int cyc; logic [15:0] w; } issue_t;
  typedef struct { int cyc; logic [NB-1:0] res; logic err; } done_t;
  issue_t iq[$];
  done_t  dq[$];

  logic bad = 1'b0;
  logic [1:0] force_v = '0;
  logic [1:0] opc = '0;

  localparam logic [16*PL-1:0] DIR = {16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001};
  localparam logic [16*PL-1:0] ES1 = {16'hA5C3, 16'h1234, 16'hFE00, 16'h0001};
  localparam logic [16*PL-1:0] ES0 = {16'hA5C3, 16'h1234, 16'hFFFF, 16'h3E00};

  morph_program_sequencer #(.ImageWidth(IW), .ImageHeight(IH), .ProgramLength(PL), .OpCounterWidth(2)) dut (
    .clk(clk), .rst(rst), .start(start), .chromosome(prog),
    .busy(busy), .done(done), .error(error),
    .el(el), .morphOp(morphOp), .morphInSelect(morphInSelect), .logicOp(logicOp),
    .ce(ce), .procRst(procRst), .opCounter(opCounter), .imageAcc(imageAcc), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // toy processor: each executed instruction rotates the image and xors the instruction in
  function automatic logic [NB-1:0] proc_f(input logic [NB-1:0] a, input logic [15:0] w);
    return {a[NB-2:0], a[NB-1]} ^ w;
  endfunction

  always @(posedge clk) begin
    if (procRst) begin
      imageAcc <= '0;
      opc      <= '0;
    end else if (ce) begin
      imageAcc <= proc_f(imageAcc, {logicOp, morphInSelect, morphOp, el});
      opc      <= opc + 2'd1;
    end
  end
  assign opCounter = bad ? force_v : opc;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  issue_t mi;
  done_t  md;
  always @(negedge clk) begin
    if (ce === 1'b1) begin
      if (iq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ce: got ce=1, expected ce=0 (cycle %0d)", cyc);
      end else begin
        mi = iq.pop_front();
        check("issue_cycle", cyc, mi.cyc);
        check("el", {23'd0, el}, {23'd0, mi.w[8:0]});
        check("morphOp", {29'd0, morphOp}, {29'd0, mi.w[11:9]});
        check("morphInSelect", {31'd0, morphInSelect}, {31'd0, mi.w[12]});
        check("logicOp", {29'd0, logicOp}, {29'd0, mi.w[15:13]});
      end
    end else begin
      check("idle_fields", {16'd0, logicOp, morphInSelect, morphOp, el}, 32'd0);
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1, expected done=0 (cycle %0d)", cyc);
      end else begin
        md = dq.pop_front();
        check("done_cycle", cyc, md.cyc);
        check("result", {16'd0, result}, {16'd0, md.res});
        check("error", {31'd0, error}, {31'd0, md.err});
      end
    end
  end

  task automatic do_run(input logic [16*PL-1:0] p, input bit noise, input bit hold);
    int n, lat, a;
    logic [NB-1:0] r;
    logic [15:0] w;
    issue_t ie;
    done_t de;
    n = PL;
`ifdef MORPH_SEQ_EARLY_STOP_EN
    for (int i = 0; i < PL; i++) if (n == PL && p[16*i +: 9] == 9'h000) n = i;
`endif
    lat = (n < PL) ? n + 3 : PL + 2;
    a = cyc + 1;
    r = '0;
    for (int i = 0; i < n; i++) begin
      w = p[16*i +: 16];
      r = proc_f(r, w);
      ie.cyc = a + 1 + i;
      ie.w = w;
      iq.push_back(ie);
    end
    de.cyc = a + lat;
    de.res = r;
    de.err = bad ? (force_v != 2'(n % 4)) : 1'b0;
    dq.push_back(de);
    prog = p;
    start = 1'b1;
    for (int j = 0; j < lat; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check("procRst_at_accept", {31'd0, procRst}, 32'd1);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("error_cleared", {31'd0, error}, 32'd0);
      end
      if (j == 1) check("procRst_cleared", {31'd0, procRst}, 32'd0);
      if (!hold) start = 1'b0;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        prog = {$urandom, $urandom};
      end
    end
    @(negedge clk);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16*PL-1:0] p;
    logic [15:0] w;
    int a;
    issue_t ie;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_error", {31'd0, error}, 32'd0);
    check("reset_result", {16'd0, result}, 32'd0);
    check("reset_ce", {31'd0, ce}, 32'd0);
    check("reset_procRst", {31'd0, procRst}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("procRst_release", {31'd0, procRst}, 32'd0);

    do_run(DIR, 1'b0, 1'b0);
    do_run(DIR, 1'b1, 1'b0);
    bad = 1'b1; force_v = 2'd1;
    do_run(DIR, 1'b0, 1'b0);
    bad = 1'b0;
    do_run(DIR, 1'b0, 1'b0);
    do_run(ES1, 1'b0, 1'b0);
    do_run(ES0, 1'b0, 1'b0);

    // abort after instruction 2 has been presented
    a = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      ie.cyc = a + 1 + i;
      ie.w = DIR[16*i +: 16];
      iq.push_back(ie);
    end
    prog = DIR;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_ce", {31'd0, ce}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_procRst", {31'd0, procRst}, 32'd1);
    check("abort_issued", iq.size(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_run(DIR, 1'b0, 1'b0);

    do_run(DIR, 1'b0, 1'b1);
    do_run(ES1, 1'b0, 1'b1);
    do_run(DIR, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < PL; i++) begin
        w = 16'($urandom);
        if ($urandom_range(0, 5) == 0) w[8:0] = 9'h000;
        p[16*i +: 16] = w;
      end
      bad = ($urandom_range(0, 3) == 0);
      force_v = 2'($urandom_range(0, 3));
      do_run(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bad = 1'b0;
    end

    repeat (3) @(negedge clk);
    check("pending_issues", iq.size(), 32'd0);
    check("pending_done", dq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/morph_program_sequencer.md
Name: morph_program_sequencer

Overview:
- Drives MorphologicProcessor: snapshots a packed program (the chromosome) on start and issues one instruction per cycle with ce.
- Clears the processor before the first instruction, then captures imageAcc and pulses done.
- Checks the processor's opCounter against the issued instruction count.
- Sits between the genetic evaluation controller and the morphologic datapath.

Parameters:
- ImageWidth, 32, image width in pixels.
- ImageHeight, 32, image height in pixels.
- ProgramLength, 4, instructions per program; must be >= 1.
- OpCounterWidth, 2, width of the processor's opCounter; count comparison is modulo 2^OpCounterWidth.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a run; sampled in IDLE only.
- program  in  16*ProgramLength  instruction i = program[16*i +: 16].
- busy  out  1  high from the first edge after start is accepted until done.
- done  out  1  one-cycle pulse; result is valid.
- error  out  1  count mismatch at capture; held until the next accepted start.
- el  out  9  to processor; instr[8:0].
- morphOp  out  3  to processor; instr[11:9].
- morphInSelect  out  1  to processor; instr[12].
- logicOp  out  3  to processor; instr[15:13].
- ce  out  1  to processor; the processor executes on the edge where ce=1.
- procRst  out  1  to processor rst (active-high), registered.
- opCounter  in  OpCounterWidth  from processor.
- imageAcc  in  ImageWidth*ImageHeight  from processor.
- result  out  ImageWidth*ImageHeight  captured image.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, busy=0, done=0, error=0, result=0, index=0, program snapshot=0.
  - procRst=1; it stays 1 until the first edge after release, then 0.
- States: IDLE, CLEAR, RUN, CAPTURE.
- IDLE: done is cleared at the next edge.
  - On start=1 at edge E0: snapshot program, error<=0, busy<=1, procRst<=1, go to CLEAR.
- CLEAR: at edge E1, procRst<=0, index<=0, go to RUN.
- RUN:
  - ce=1 (combinational).
  - Instruction fields decoded combinationally from snapshot[index].
  - Each edge increments index.
  - At the edge where index==ProgramLength-1, go to CAPTURE.
  - The processor executes instructions 0..N-1 on edges E2..E(N+1).
- CAPTURE: at edge E(N+2):
  - result<=imageAcc, done<=1, busy<=0.
  - error<=(opCounter != executed count mod 2^OpCounterWidth).
  - Go to IDLE.
- Outside RUN: ce=0 and el, morphOp, morphInSelect, logicOp are all 0.
- Latency: done is high during the cycle after E(N+2), i.e. N+2 edges after start is accepted.
- start while busy is ignored.
- Changes to program after E0 have no effect on the current run.
- start held high: a new run is accepted on the edge after done (state is IDLE again).
- ProgramLength=1: RUN lasts exactly one cycle.
- Reset mid-run: immediate return to reset values; ce drops asynchronously; no done pulse.
- Index is an internal counter of ceil(log2(ProgramLength+1)) bits; it never wraps.

Optional Feature:
- Macro: MORPH_SEQ_EARLY_STOP_EN.
- Enabled:
  - An instruction with el==9'h000 is an end marker.
  - In RUN, if snapshot[index] is a marker, ce=0 and fields are 0 that cycle; go to CAPTURE at that edge.
  - Executed count = index of the marker; error uses this count.
  - A marker at index 0 gives zero operations; done arrives 2 edges after E1.
- Disabled: el==0 is an ordinary instruction; all ProgramLength instructions are always issued.

Test Plan:
- Reset: hold rst=0 -> busy=0, done=0, error=0, result=0, ce=0, procRst=1. Release, one edge -> procRst=0.
- Normal run, ProgramLength=4, program={16'hA5C3,16'h1234,16'hFFFF,16'h0001}, real processor 4x4, start at E0:
  - procRst=1 between E0 and E1.
  - ce=1 for exactly 4 cycles.
  - Fields in order: el=001/mOp=0/sel=0/lOp=0; then 1FF/7/1/7; then 034/1/1/0; then 1C3/2/0/5.
  - done pulses after E6; result==processor imageAcc; error=0 (opCounter wrapped to 0).
- Busy robustness: pulse start and flip program to 0 during RUN -> no restart; issued fields unchanged; single done pulse.
- Mismatch: stub processor holding opCounter=2'd1 -> done with error=1. Next start -> error cleared at acceptance.
- Reset mid-run: assert rst while index=2 -> ce=0 and busy=0 immediately; no done. After release and a new start, all 4 instructions are issued.
- Early stop, macro enabled, instr1.el=0:
  - ce=1 for 1 cycle only; done after E4; error=0 when opCounter=1.
  - Same stimulus with macro disabled -> 4 issues; done after E6.
